// File: rtl/aes_tx_pkg.sv
// Shared constants and helpers for the aes_tx word schedulers.
// Header word layout: {sync byte, source id, per-source sequence number}.
package aes_tx_pkg;

  localparam logic [7:0] HDR_SYNC = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_BODY = 2'd2
  } state_e;

  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_ID_LSB   = 16;
  localparam int HDR_SEQ_LSB  = 0;

  function automatic logic [31:0] make_header(input logic [7:0]  id,
                                              input logic [15:0] seq);
    logic [31:0] hdr;
    hdr                      = '0;
    hdr[HDR_SYNC_LSB +: 8]   = HDR_SYNC;
    hdr[HDR_ID_LSB   +: 8]   = id;
    hdr[HDR_SEQ_LSB  +: 16]  = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/aes_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping. Shared by the tx scheduler and the planned rx-side scheduler.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    // NOTE: every output gets a default before the search so no path through
    // the loop leaves it unassigned (which would infer a latch).
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/aes_tx_sched.sv
// Packet scheduler sharing one aes_tx word port between NUM_SRC show-ahead
// FIFOs: one source owns the port for a header plus WORDS_PER_PKT body words.
module aes_tx_sched
  import aes_tx_pkg::*;
#(
  parameter int NUM_SRC       = 2,
  parameter int WORDS_PER_PKT = 4,
  parameter int HEADER_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [32*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]    src_empty,
  output logic [NUM_SRC-1:0]    src_rd,
  output logic [31:0]           tx_data,
  output logic                  tx_empty,
  input  logic                  tx_require,
  output logic [NUM_SRC-1:0]    grant,
  output logic                  busy,
  output logic                  err
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(WORDS_PER_PKT) + 1;

  state_e                     state_q, state_d;
  logic [NUM_SRC-1:0]         grant_q, grant_d;
  logic [IW-1:0]              id_q, id_d;
  logic [IW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]              word_cnt_q, word_cnt_d;
  logic [NUM_SRC-1:0][15:0]   seq_q, seq_d;
  logic                       err_q, err_d;

  logic [NUM_SRC-1:0]         src_req;
  logic [NUM_SRC-1:0]         arb_gnt;
  logic [IW-1:0]              arb_id;

  assign src_req = ~src_empty;

  rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_arb (
    .req    (src_req),
    .ptr    (rr_ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      id_q       <= '0;
      rr_ptr_q   <= '0;
      word_cnt_q <= '0;
      seq_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      id_q       <= id_d;
      rr_ptr_q   <= rr_ptr_d;
      word_cnt_q <= word_cnt_d;
      seq_q      <= seq_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    id_d       = id_q;
    rr_ptr_d   = rr_ptr_q;
    word_cnt_d = word_cnt_q;
    seq_d      = seq_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (tx_require) err_d = 1'b1;
        if (|src_req) begin
          grant_d    = arb_gnt;
          id_d       = arb_id;
          word_cnt_d = '0;
          state_d    = (HEADER_EN != 0) ? S_HDR : S_BODY;
        end
      end
      S_HDR: begin
        if (tx_require) begin
          state_d    = S_BODY;
          word_cnt_d = '0;
        end
      end
      S_BODY: begin
        if (tx_require) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == CW'(WORDS_PER_PKT - 1)) begin
            state_d     = S_IDLE;
            grant_d     = '0;
            word_cnt_d  = '0;
            seq_d[id_q] = seq_q[id_q] + 16'd1;
            rr_ptr_d    = (id_q == IW'(NUM_SRC - 1)) ? '0 : id_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The current word is held until its tx_require; pop in that same cycle.
  always_comb begin
    tx_data  = '0;
    tx_empty = 1'b1;
    src_rd   = '0;
    case (state_q)
      S_HDR: begin
        tx_data  = make_header(8'(id_q), seq_q[id_q]);
        tx_empty = 1'b0;
      end
      S_BODY: begin
        tx_data  = src_data[32*int'(id_q) +: 32];
        tx_empty = src_empty[id_q];
        if (tx_require) src_rd = grant_q;
      end
      default: ;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != S_IDLE);
  assign err   = err_q;

  a_no_take_from_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == S_BODY && tx_require && src_empty[id_q]));

endmodule
